// File: rtl/npu_output_packer.sv
// -----------------------------------------------------------------------------
// npu_output_packer
//
// Drains 32-bit result words from the NPU output FIFO, packs PACK consecutive
// words into one wide RAM word (first word in the LSBs) and writes it to the
// result RAM at a self-generated address that wraps from LAST_ADDR back to
// BASE_ADDR. A flush request emits a partially filled word with the unfilled
// lanes zero.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   fifo_empty  output FIFO empty
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  FIFO read strobe
//   flush       single-cycle request to emit the partial word
//   ram_ready   RAM accepts a write this cycle
//   ram_we      write valid, held until accepted
//   ram_addr    write address
//   ram_data    packed write data
//   frame_done  one-cycle pulse the cycle after a flush executes
//   wrap        one-cycle pulse after an accepted write at LAST_ADDR
// -----------------------------------------------------------------------------

// One lane of the pack register. nxt is the lane contents including a word
// being captured this cycle, so a completing pack can be forwarded straight
// into the output register.
module npu_output_packer_lane #(
   parameter int IN_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            load,
   input  logic [IN_W-1:0] d,
   output logic [IN_W-1:0] q,
   output logic [IN_W-1:0] nxt
);

   assign nxt = load ? d : q;

   // clear wins over load: the last lane of a completing pack is forwarded
   // through nxt and must not linger in the register.
   always_ff @(posedge clk) begin
      if (reset || clear) q <= '0;
      else if (load)      q <= d;
   end

endmodule

module npu_output_packer #(
   parameter int                IN_W      = 32,
   parameter int                PACK      = 2,
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}}
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fifo_empty,
   input  logic [IN_W-1:0]      fifo_data,
   output logic                 fifo_rd_en,
   input  logic                 flush,
   input  logic                 ram_ready,
   output logic                 ram_we,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic [IN_W*PACK-1:0] ram_data,
   output logic                 frame_done,
   output logic                 wrap
);

   localparam int                LANE_W    = (PACK > 1) ? $clog2(PACK) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);
   localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   logic [LANE_W-1:0]           lane_q;
   logic                        rd_pend_q;
   logic                        out_valid_q;
   logic                        flush_req_q;
   logic                        frame_done_q;
   logic                        wrap_q;
   logic [ADDR_W-1:0]           addr_q;
   logic [IN_W*PACK-1:0]        data_q;

   logic [PACK-1:0][IN_W-1:0]   pack_q;
   logic [PACK-1:0][IN_W-1:0]   pack_nxt;
   logic [PACK-1:0]             lane_hit;

   logic                        capture;
   logic                        complete;
   logic                        flush_exec;
   logic                        partial;
   logic                        accept;
   logic                        at_last;

   // ---------------------------------------------------------------------------
   // Control terms
   // ---------------------------------------------------------------------------
   assign capture    = rd_pend_q;
   assign complete   = rd_pend_q && (lane_q == LAST_LANE);
   // A flush waits for the in-flight word to land and the held output to go,
   // so the partial word always contains every word read before it.
   assign flush_exec = flush_req_q && !rd_pend_q && !out_valid_q;
   assign partial    = flush_exec && (lane_q != '0);
   assign accept     = out_valid_q && ram_ready;
   assign at_last    = (addr_q == LAST_ADDR);

   // Reads stop while an output is held: with PACK >= 2 at most one more word
   // (already in flight) can arrive, so a second pack can never complete on
   // top of an unaccepted one.
   assign fifo_rd_en = !reset && !fifo_empty && !out_valid_q && !flush_req_q;

   // ---------------------------------------------------------------------------
   // Pack register, one instance per lane
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < PACK; g++) begin : g_lane
      assign lane_hit[g] = capture && (lane_q == LANE_W'(g));

      npu_output_packer_lane #(.IN_W(IN_W)) u_lane (
         .clk   (clk),
         .reset (reset),
         .clear (complete || flush_exec),
         .load  (lane_hit[g]),
         .d     (fifo_data),
         .q     (pack_q[g]),
         .nxt   (pack_nxt[g])
      );
   end

   // ---------------------------------------------------------------------------
   // Lane counter and read tracking
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q    <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         rd_pend_q <= fifo_rd_en;
         if (complete || partial) lane_q <= '0;
         else if (capture)        lane_q <= lane_q + LANE_ONE;
      end
   end

   // ---------------------------------------------------------------------------
   // Output register and write handshake
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         data_q      <= '0;
         addr_q      <= BASE_ADDR;
         wrap_q      <= 1'b0;
      end else begin
         wrap_q <= accept && at_last;
         if (accept) begin
            out_valid_q <= 1'b0;
            addr_q      <= at_last ? BASE_ADDR : addr_q + ADDR_ONE;
         end
         // Loading only happens with out_valid_q low, so it never collides
         // with an accept; set still takes priority for clarity.
         if (complete) begin
            data_q      <= pack_nxt;
            out_valid_q <= 1'b1;
         end else if (partial) begin
            data_q      <= pack_q;
            out_valid_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Flush request; a second flush while one is pending is absorbed
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         flush_req_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= flush_exec;
         if (flush_exec) flush_req_q <= 1'b0;
         else if (flush) flush_req_q <= 1'b1;
      end
   end

   assign ram_we     = out_valid_q;
   assign ram_addr   = addr_q;
   assign ram_data   = data_q;
   assign frame_done = frame_done_q;
   assign wrap       = wrap_q;

endmodule
